// File: rtl/instr_fetch_pkg.sv
// Shared types and default parameters for the instruction fetch front end.
package instr_fetch_pkg;

  typedef logic [15:0] pc_t;
  typedef logic [8:0]  inst_t;

  localparam int  AW_DEF    = 16;
  localparam int  IW_DEF    = 9;
  localparam int  DEPTH_DEF = 4;
  localparam pc_t RESET_PC  = 16'h0000;

endpackage

// File: rtl/instr_fetch_buf.sv
// Circular buffer of fetch slots: allocated in request order, filled in
// response order and popped in program order; flush discards every slot.
module fetch_buf
  import instr_fetch_pkg::*;
#(
  parameter int  AW    = AW_DEF,
  parameter int  IW    = IW_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_pc,
  input  logic          fill_en,
  input  logic [IW-1:0] fill_data,
  input  logic          pop_en,
  input  logic          flush,
  output logic          head_filled,
  output logic [AW-1:0] head_pc,
  output logic [IW-1:0] head_data,
  output logic [CW-1:0] occupancy,
  output logic [CW-1:0] unfilled
);

  // Pointers carry one extra wrap bit so that full and empty differ.
  logic [CW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [CW-1:0]    fill_ptr_q,  fill_ptr_d;
  logic [CW-1:0]    head_ptr_q,  head_ptr_d;
  logic [DEPTH-1:0] filled_q,    filled_d;
  logic [AW-1:0]    pc_q   [DEPTH];
  logic [AW-1:0]    pc_d   [DEPTH];
  logic [IW-1:0]    data_q [DEPTH];
  logic [IW-1:0]    data_d [DEPTH];

  logic [PW-1:0] alloc_idx;
  logic [PW-1:0] fill_idx;
  logic [PW-1:0] head_idx;

  assign alloc_idx = alloc_ptr_q[PW-1:0];
  assign fill_idx  = fill_ptr_q[PW-1:0];
  assign head_idx  = head_ptr_q[PW-1:0];

  assign head_filled = filled_q[head_idx];
  assign head_pc     = pc_q[head_idx];
  assign head_data   = data_q[head_idx];
  assign occupancy   = alloc_ptr_q - head_ptr_q;
  assign unfilled    = alloc_ptr_q - fill_ptr_q;

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    filled_d    = filled_q;
    pc_d        = pc_q;
    data_d      = data_q;

    if (alloc_en) begin
      pc_d[alloc_idx]     = alloc_pc;
      filled_d[alloc_idx] = 1'b0;
      alloc_ptr_d         = alloc_ptr_q + 1'b1;
    end

    if (fill_en) begin
      data_d[fill_idx]   = fill_data;
      filled_d[fill_idx] = 1'b1;
      fill_ptr_d         = fill_ptr_q + 1'b1;
    end

    if (pop_en) begin
      filled_d[head_idx] = 1'b0;
      head_ptr_d         = head_ptr_q + 1'b1;
    end

    // A same-cycle pop still retires; everything behind it is discarded.
    if (flush) begin
      filled_d    = '0;
      alloc_ptr_d = head_ptr_d;
      fill_ptr_d  = head_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      filled_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      filled_q    <= filled_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the sequential fetch PC, issues in-order
// memory reads, and hands PC-tagged words to decode over valid/ready.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            IW       = IW_DEF,
  parameter int            DEPTH    = DEPTH_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(instr_fetch_pkg::RESET_PC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] inst_pc
);

  localparam int          CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] occupancy;
  logic [CW-1:0] unfilled;
  logic [CW:0]   in_use;
  logic          head_filled;
  logic          req_fire;
  logic          fill_en;
  logic          pop_en;
  logic          rsp_owed;

  // Buffered slots plus responses still to be discarded share the DEPTH budget.
  assign in_use         = {1'b0, occupancy} + {1'b0, drop_cnt_q};
  assign imem_req_valid = reset && !halt && (in_use < DEPTH_LIM);
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = head_filled;
  assign pop_en     = head_filled && inst_ready;
  assign fill_en    = imem_rsp_valid && !redirect_valid &&
                      (drop_cnt_q == '0) && (unfilled != '0);
  assign rsp_owed   = imem_rsp_valid && ((drop_cnt_q != '0) || (unfilled != '0));

  fetch_buf #(
    .AW    (AW),
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (reset),
    .alloc_en    (req_fire && !redirect_valid),
    .alloc_pc    (fetch_pc_q),
    .fill_en     (fill_en),
    .fill_data   (imem_rsp_data),
    .pop_en      (pop_en),
    .flush       (redirect_valid),
    .head_filled (head_filled),
    .head_pc     (inst_pc),
    .head_data   (inst),
    .occupancy   (occupancy),
    .unfilled    (unfilled)
  );

  // On redirect every request memory still owes us becomes a drop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_cnt_d = drop_cnt_q + unfilled + CW'(req_fire) - CW'(rsp_owed);
    end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: start-up vector table, directed redirect/halt/wrap/reset
// sequences, and randomized traffic checked against a program-order model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic  clk = 1'b0;
  logic  reset;
  logic  halt;
  logic  redirect_valid;
  pc_t   redirect_pc;
  logic  imem_req_valid;
  logic  imem_req_ready;
  pc_t   imem_addr;
  logic  imem_rsp_valid;
  inst_t imem_rsp_data;
  logic  inst_valid;
  logic  inst_ready;
  inst_t inst;
  pc_t   inst_pc;

  always #5 clk = ~clk;

  instr_fetch #(
    .AW       (16),
    .IW       (9),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  // Memory holds accepted reads tagged with the redirect epoch they belong to;
  // the delivery queue holds words decode is entitled to see, in order.
  typedef struct { pc_t addr; int epoch; int due; } mem_req_t;
  typedef struct { pc_t pc; inst_t data; } word_t;
  typedef struct { bit rst; bit ir; bit exp_rv; pc_t exp_addr; bit exp_iv; pc_t exp_pc; } vec_t;

  mem_req_t mem_q[$];
  word_t    deliver_q[$];
  vec_t     vecs[$];
  pc_t      model_pc;
  int       epoch;
  int       cycle;
  int       lat_lo;
  int       lat_hi;
  int       checks;
  int       errors;
  logic     exp_req_valid;

  function automatic inst_t mem_word(input pc_t a);
    pc_t t;
    t = (a * 16'd7) + 16'd3;
    return inst_t'(t[8:0] ^ t[15:7]);
  endfunction

  task automatic compareValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected event (cycle %0d)", name, cycle);
  endtask

  task automatic applyStimulus(input logic h, input logic ir, input logic rr, input logic rv, input pc_t rpc);
    halt           = h;
    inst_ready     = ir;
    imem_req_ready = rr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic checkOutput();
    exp_req_valid = !halt && ((mem_q.size() + deliver_q.size()) < DEPTH);
    compareValue("req_valid", imem_req_valid, exp_req_valid);
    if (exp_req_valid) compareValue("imem_addr", imem_addr, model_pc);
    compareValue("inst_valid", inst_valid, deliver_q.size() > 0);
    if (deliver_q.size() > 0) begin
      compareValue("inst_pc", inst_pc, deliver_q[0].pc);
      compareValue("inst", inst, deliver_q[0].data);
    end
  endtask

  task automatic updateModel();
    bit req_hs;
    bit cons;
    req_hs = exp_req_valid && imem_req_ready;
    cons   = (deliver_q.size() > 0) && inst_ready;
    if (cons) void'(deliver_q.pop_front());
    if (imem_rsp_valid) begin
      mem_req_t e;
      e = mem_q.pop_front();
      if (!redirect_valid && e.epoch == epoch) deliver_q.push_back('{e.addr, mem_word(e.addr)});
    end
    if (req_hs) begin
      mem_q.push_back('{model_pc, epoch, cycle + int'($urandom_range(lat_hi, lat_lo))});
      model_pc = model_pc + 16'd1;
    end
    if (redirect_valid) begin
      epoch++;
      deliver_q.delete();
      model_pc = redirect_pc;
    end
  endtask

  task automatic stepHalf(input logic h, input logic ir, input logic rr, input logic rv, input pc_t rpc);
    applyStimulus(h, ir, rr, rv, rpc);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic stepFinish();
    updateModel();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic runCycle(input logic h, input logic ir, input logic rr, input logic rv, input pc_t rpc);
    stepHalf(h, ir, rr, rv, rpc);
    stepFinish();
  endtask

  task automatic doReset();
    reset          = 1'b0;
    halt           = 1'b0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_q.delete();
    deliver_q.delete();
    model_pc = 16'h0000;
    epoch    = 0;
    #2;
    compareValue("reset_inst_valid", inst_valid, 1'b0);
    compareValue("reset_req_valid", imem_req_valid, 1'b0);
    compareValue("reset_addr", imem_addr, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic waitFirstPc(input string name, input pc_t want);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      stepHalf(1'b0, 1'b1, 1'b1, 1'b0, '0);
      if (inst_valid) begin
        compareValue(name, inst_pc, want);
        found = 1'b1;
      end
      stepFinish();
    end
    if (!found) timeoutFail(name);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int delivered;
    checks = 0;
    errors = 0;
    cycle  = 0;
    lat_lo = 1;
    lat_hi = 1;

    // rst, inst_ready, exp req_valid, exp addr, exp inst_valid, exp inst_pc
    vecs.push_back('{1, 1, 1, 16'd0, 0, 16'd0});
    vecs.push_back('{0, 1, 1, 16'd1, 0, 16'd0});
    vecs.push_back('{0, 1, 1, 16'd2, 1, 16'd0});
    vecs.push_back('{0, 1, 1, 16'd3, 1, 16'd1});
    vecs.push_back('{0, 1, 1, 16'd4, 1, 16'd2});
    vecs.push_back('{0, 1, 1, 16'd5, 1, 16'd3});
    vecs.push_back('{1, 0, 1, 16'd0, 0, 16'd0});
    vecs.push_back('{0, 0, 1, 16'd1, 0, 16'd0});
    vecs.push_back('{0, 0, 1, 16'd2, 1, 16'd0});
    vecs.push_back('{0, 0, 1, 16'd3, 1, 16'd0});
    for (int i = 0; i < 6; i++) vecs.push_back('{0, 0, 0, 16'd0, 1, 16'd0});
    vecs.push_back('{0, 1, 0, 16'd0, 1, 16'd0});
    vecs.push_back('{0, 1, 1, 16'd4, 1, 16'd1});
    vecs.push_back('{0, 1, 1, 16'd5, 1, 16'd2});
    vecs.push_back('{0, 1, 1, 16'd6, 1, 16'd3});
    vecs.push_back('{0, 1, 1, 16'd7, 1, 16'd4});
    vecs.push_back('{0, 1, 1, 16'd8, 1, 16'd5});

    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      stepHalf(1'b0, vecs[i].ir, 1'b1, 1'b0, '0);
      compareValue("tbl_req_valid", imem_req_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv) compareValue("tbl_addr", imem_addr, vecs[i].exp_addr);
      compareValue("tbl_inst_valid", inst_valid, vecs[i].exp_iv);
      if (vecs[i].exp_iv) compareValue("tbl_inst_pc", inst_pc, vecs[i].exp_pc);
      stepFinish();
    end

    $display("[TB] redirect with late responses in flight");
    doReset();
    lat_lo = 3;
    lat_hi = 3;
    for (int n = 0; n < 40 && model_pc != 16'd7; n++) runCycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    runCycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040);
    stepHalf(1'b0, 1'b1, 1'b1, 1'b0, '0);
    compareValue("post_redirect_valid", inst_valid, 1'b0);
    compareValue("post_redirect_addr", imem_addr, 16'h0040);
    stepFinish();
    waitFirstPc("first_pc_after_redirect", 16'h0040);

    $display("[TB] redirect with same-cycle request and response");
    doReset();
    lat_lo = 1;
    lat_hi = 1;
    for (int n = 0; n < 6; n++) runCycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    stepHalf(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
    compareValue("redirect_cycle_req", imem_req_valid, 1'b1);
    stepFinish();
    stepHalf(1'b0, 1'b1, 1'b1, 1'b0, '0);
    compareValue("post_redirect_valid2", inst_valid, 1'b0);
    stepFinish();
    waitFirstPc("first_pc_after_redirect2", 16'h1234);

    $display("[TB] halt with two outstanding");
    doReset();
    lat_lo = 3;
    lat_hi = 3;
    runCycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    runCycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    delivered = 0;
    for (int n = 0; n < 8; n++) begin
      stepHalf(1'b1, 1'b1, 1'b1, 1'b0, '0);
      if (inst_valid) delivered++;
      stepFinish();
    end
    compareValue("halt_delivered", delivered, 2);
    stepHalf(1'b0, 1'b1, 1'b1, 1'b0, '0);
    compareValue("halt_resume_valid", imem_req_valid, 1'b1);
    compareValue("halt_resume_addr", imem_addr, 16'h0002);
    stepFinish();
    runCycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0100);
    stepHalf(1'b0, 1'b1, 1'b1, 1'b0, '0);
    compareValue("halted_redirect_addr", imem_addr, 16'h0100);
    stepFinish();
    for (int n = 0; n < 8; n++) runCycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

    $display("[TB] address wrap and asynchronous reset");
    lat_lo = 1;
    lat_hi = 1;
    runCycle(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    stepHalf(1'b0, 1'b1, 1'b1, 1'b0, '0);
    compareValue("wrap_addr_ffff", imem_addr, 16'hFFFF);
    stepFinish();
    stepHalf(1'b0, 1'b1, 1'b1, 1'b0, '0);
    compareValue("wrap_addr_0000", imem_addr, 16'h0000);
    stepFinish();
    for (int n = 0; n < 3; n++) runCycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    stepHalf(1'b0, 1'b1, 1'b1, 1'b0, '0);
    compareValue("pre_reset_valid", inst_valid, 1'b1);
    stepFinish();
    #2;
    doReset();
    stepHalf(1'b0, 1'b1, 1'b1, 1'b0, '0);
    compareValue("post_reset_req_valid", imem_req_valid, 1'b1);
    compareValue("post_reset_addr", imem_addr, 16'h0000);
    stepFinish();

    $display("[TB] randomized traffic");
    doReset();
    lat_lo = 1;
    lat_hi = 4;
    for (int n = 0; n < 1500; n++) begin
      runCycle($urandom_range(9, 0) == 0,
               $urandom_range(9, 0) < 7,
               $urandom_range(3, 0) != 0,
               $urandom_range(19, 0) == 0,
               ($urandom_range(3, 0) == 0) ? 16'hFFFE : pc_t'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch front end. Issues in-order reads to instruction memory and returns each instruction word, tagged with its PC, to decode over a valid/ready interface.
- Sequential fetch PC is owned here. Branch/jump targets computed downstream arrive on the redirect port; a redirect flushes buffered and in-flight fetches.
- Memory latency is variable, and up to DEPTH requests may be outstanding at once.

Parameters:
- AW, 16, PC/address width.
- IW, 9, instruction word width.
- DEPTH, 4, buffer entries and maximum outstanding plus buffered fetches (power of 2, at least 2).
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- halt  in  1  when high, no new memory requests are issued.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  AW  new fetch target.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  AW  request address, equal to fetch_pc.
- imem_rsp_valid  in  1  read data valid; responses return in order; no backpressure.
- imem_rsp_data  in  IW  read data.
- inst_valid  out  1  head instruction available.
- inst_ready  in  1  decode accepts it.
- inst  out  IW  instruction word.
- inst_pc  out  AW  PC of that instruction.

Behaviour:
- State: fetch_pc (AW), buffer of DEPTH entries {pc, data, filled}, head/tail/alloc pointers, occupancy count, drop_cnt.
- Reset (async, reset low): fetch_pc=RESET_PC, all pointers/counts/drop_cnt=0, all filled=0. Outputs during reset: inst_valid=0, imem_req_valid=0.
- imem_req_valid = !halt && (occupancy < DEPTH) && reset deasserted. Combinational from state and halt only; it never depends on imem_req_ready.
- Request handshake (valid && ready):
  - Allocate the tail entry with pc=fetch_pc, filled=0.
  - fetch_pc <= fetch_pc+1, with wrap at 2^AW.
  - occupancy +1.
- Response (imem_rsp_valid):
  - If drop_cnt>0: discard the response, drop_cnt -1.
  - Otherwise write data into the oldest unfilled entry and set filled=1.
- Output: inst_valid = head.filled. inst and inst_pc come from the head entry.
- Consume handshake (inst_valid && inst_ready): free the head, occupancy -1.
- Minimum latency: request accepted in cycle N, response in cycle N+k, inst_valid in cycle N+k+1 (registered fill).
- Full: occupancy==DEPTH holds imem_req_valid=0. A consume and a request in the same cycle are both honoured, leaving occupancy unchanged.
- Redirect (redirect_valid=1), taking effect at the clock edge:
  - fetch_pc <= redirect_pc. This wins over the +1 from a same-cycle request.
  - drop_cnt <= drop_cnt + (unfilled entries) + (1 if a request handshakes this cycle) − (1 if a response arrives this cycle and drop_cnt==0 would not absorb it). Equivalently, every request already accepted by memory and not yet returned is dropped.
  - A response in the redirect cycle is discarded.
  - A consume in the redirect cycle completes normally, since decode took the word. All remaining entries are flushed: occupancy=0, filled=0, pointers realigned.
  - In the cycle after the redirect, inst_valid=0.
- While drop_cnt>0, new requests may still be issued. Drop_cnt plus occupancy never exceeds DEPTH, so imem_req_valid additionally requires occupancy+drop_cnt < DEPTH.
- halt:
  - Blocks only new requests.
  - Outstanding responses still fill.
  - Buffered instructions still drain.
  - A redirect while halted still updates fetch_pc.
- Reset asserted mid-operation clears everything immediately. Responses from before reset must not reach decode; the memory model is reset from the same signal.

Decomposition:
- Add to package definitions:
  - typedef logic [15:0] pc_t;
  - typedef logic [8:0] inst_t;
  - localparam RESET_PC.
- One sub-module, fetch_buf: a DEPTH-entry circular buffer with separate alloc, fill and pop pointers and a flush input. instr_fetch keeps fetch_pc, drop_cnt and the handshake logic.

Test Plan:
- Reset release, memory with 1-cycle latency, inst_ready=1 → imem_addr sequence 0,1,2,3…; inst_pc 0,1,2 with matching data; one instruction per cycle in steady state.
- inst_ready=0 for 10 cycles → exactly DEPTH=4 requests (addr 0–3), then imem_req_valid=0. Set inst_ready=1 → words 0–3 in order, fetching resumes at addr 4.
- 3-cycle memory latency with requests at 5,6 in flight; redirect_pc=0x0040 → the 2 late responses are discarded; next imem_addr=0x0040; first inst_pc after the redirect is 0x0040.
- Redirect in the same cycle as a request handshake and a response → the request and response are both dropped, fetch_pc=redirect_pc, no stale inst_pc ever appears.
- halt=1 with 2 outstanding → no new requests; the 2 words are delivered; halt=0 resumes at the next sequential address.
- fetch_pc=0xFFFF, request accepted → next imem_addr=0x0000. Async reset pulsed mid-burst → inst_valid=0 immediately and imem_addr=RESET_PC after release.
